// File: rtl/fft_pkg.sv
// Shared definitions for the FFT32 butterfly datapath blocks.
package fft_pkg;

  // Default datapath width of the butterfly.
  localparam int DATA_W = 16;

  // Per-beat arithmetic mode carried on the 'sub' input.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Legal segmentation: width at least 2, 1..n segments, equal-width slices.
  function automatic bit segs_valid(input int n, input int segs);
    return (n >= 2) && (segs >= 1) && (segs <= n) && ((n % segs) == 0);
  endfunction

endpackage

// File: rtl/pipelined_addsub_segment.sv
// One W-bit ripple-carry slice of the segmented adder; purely combinational.
module addsub_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  // Chain of full-adder cells, least significant bit first.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[W];

endmodule

// File: rtl/pipelined_addsub.sv
// Segmented, pipelined two's-complement adder/subtractor with optional
// divide-by-2 scaling, carry/overflow flags and a valid/ready handshake.
module pipelined_addsub
  import fft_pkg::*;
#(
  parameter int N    = DATA_W,
  parameter int SEGS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         scale,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry_out,
  output logic         overflow
);

  localparam int W = N / SEGS;

  if (!segs_valid(N, SEGS)) begin : g_param_check
    $error("pipelined_addsub: N must be >= 2 and a multiple of SEGS, SEGS in 1..N");
  end

  // Select the N result bits from the exact (N+1)-bit result.
  function automatic logic [N-1:0] scale_select(input logic [N:0] r, input logic do_scale);
    return do_scale ? r[N:1] : r[N-1:0];
  endfunction

  // Signed overflow of the unscaled result; meaningless once halved.
  function automatic logic ovf_detect(input logic am, input logic bm, input logic rm,
                                      input logic do_scale);
    return !do_scale && (am == bm) && (rm != am);
  endfunction

  logic         out_valid_q;
  logic [N-1:0] sum_q;
  logic         carry_q;
  logic         ovf_q;
  logic         en;
  logic         c0;
  logic [N-1:0] b_eff;

  // Whole pipeline advances together; it only freezes on a stalled result.
  assign en       = out_ready || !out_valid_q;
  assign in_ready = en;

  assign c0    = (op_e'(sub) == OP_SUB);
  assign b_eff = c0 ? ~b : b;

  // ---- stages 0..SEGS-2: one slice added per stage, upper operands skewed ----
  for (genvar s = 0; s < SEGS - 1; s++) begin : g_stg
    localparam int LO = (s + 1) * W;
    localparam int HI = N - LO;

    logic [W-1:0]  seg_a, seg_b, seg_s;
    logic          seg_ci, seg_co;
    logic [LO-1:0] lo_d, lo_q;
    logic [HI-1:0] ahi_d, bhi_d, ahi_q, bhi_q;
    logic          vld_d, scale_d, vld_q, scale_q, c_q;

    if (s == 0) begin : g_src
      assign seg_a   = a[W-1:0];
      assign seg_b   = b_eff[W-1:0];
      assign seg_ci  = c0;
      assign lo_d    = seg_s;
      assign ahi_d   = a[N-1:W];
      assign bhi_d   = b_eff[N-1:W];
      assign vld_d   = in_valid;
      assign scale_d = scale;
    end else begin : g_src
      assign seg_a   = g_stg[s-1].ahi_q[W-1:0];
      assign seg_b   = g_stg[s-1].bhi_q[W-1:0];
      assign seg_ci  = g_stg[s-1].c_q;
      assign lo_d    = {seg_s, g_stg[s-1].lo_q};
      assign ahi_d   = g_stg[s-1].ahi_q[HI+W-1:W];
      assign bhi_d   = g_stg[s-1].bhi_q[HI+W-1:W];
      assign vld_d   = g_stg[s-1].vld_q;
      assign scale_d = g_stg[s-1].scale_q;
    end

    addsub_segment #(.W(W)) u_seg (
      .a    (seg_a),
      .b    (seg_b),
      .cin  (seg_ci),
      .sum  (seg_s),
      .cout (seg_co)
    );

    // Register this stage's partial result, carry, skewed operands and tags.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q   <= 1'b0;
        scale_q <= 1'b0;
        c_q     <= 1'b0;
        lo_q    <= '0;
        ahi_q   <= '0;
        bhi_q   <= '0;
      end else if (en) begin
        vld_q   <= vld_d;
        scale_q <= scale_d;
        c_q     <= seg_co;
        lo_q    <= lo_d;
        ahi_q   <= ahi_d;
        bhi_q   <= bhi_d;
      end
    end
  end

  // ---- final stage: top slice, flags and output registers ----
  logic [W-1:0] fa, fb, fs;
  logic         fci, fco;
  logic [N-1:0] raw;
  logic         fam, fbm, fvld, fscale;
  logic [N:0]   full_r;

  if (SEGS == 1) begin : g_last
    assign fa     = a;
    assign fb     = b_eff;
    assign fci    = c0;
    assign raw    = fs;
    assign fam    = a[N-1];
    assign fbm    = b_eff[N-1];
    assign fvld   = in_valid;
    assign fscale = scale;
  end else begin : g_last
    assign fa     = g_stg[SEGS-2].ahi_q;
    assign fb     = g_stg[SEGS-2].bhi_q;
    assign fci    = g_stg[SEGS-2].c_q;
    assign raw    = {fs, g_stg[SEGS-2].lo_q};
    assign fam    = g_stg[SEGS-2].ahi_q[W-1];
    assign fbm    = g_stg[SEGS-2].bhi_q[W-1];
    assign fvld   = g_stg[SEGS-2].vld_q;
    assign fscale = g_stg[SEGS-2].scale_q;
  end

  addsub_segment #(.W(W)) u_seg_last (
    .a    (fa),
    .b    (fb),
    .cin  (fci),
    .sum  (fs),
    .cout (fco)
  );

  assign full_r = {fam ^ fbm ^ fco, raw};

  // Output register: holds the result until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= fvld;
      sum_q       <= scale_select(full_r, fscale);
      carry_q     <= fco;
      ovf_q       <= ovf_detect(fam, fbm, raw[N-1], fscale);
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub at N=16, SEGS=4.
module tb_pipelined_addsub;

  localparam int N    = 16;
  localparam int SEGS = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a, b;
  logic         sub, scale;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  pipelined_addsub #(.N(N), .SEGS(SEGS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .scale     (scale),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        scale;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Exact signed arithmetic reference: returns {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic msub, input logic mscale);
    logic signed [16:0] r;
    logic [16:0]        u;
    logic [15:0]        s;
    logic               o;
    if (msub) begin
      r = $signed({ma[15], ma}) - $signed({mb[15], mb});
      u = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
    end else begin
      r = $signed({ma[15], ma}) + $signed({mb[15], mb});
      u = {1'b0, ma} + {1'b0, mb};
    end
    s = mscale ? r[16:1] : r[15:0];
    o = !mscale && (r[16] != r[15]);
    return {o, u[16], s};
  endfunction

  // Issue one beat, then wait a bounded time for its result and check it.
  task automatic run_vec(input string nm, input vec_t v);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    a = v.a; b = v.b; sub = v.sub; scale = v.scale;
    chk({nm, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, k, SEGS - 1);
    chk({nm, "_sum"}, sum, v.sum);
    chk({nm, "_carry"}, carry_out, v.cout);
    chk({nm, "_ovf"}, overflow, v.ovf);
    @(negedge clk);
    chk({nm, "_single"}, out_valid, 0);
  endtask

  logic [15:0] ba [8];
  logic [15:0] bb [8];
  logic        bs [8];
  logic        bc [8];
  logic [17:0] expq [$];
  logic [17:0] e;
  logic [15:0] held_sum;
  bit          prev_stall;
  int          idx, got, cyc;
  vec_t        v_post;

  initial begin
    //            a        b        sub   scale  sum      cout  ovf
    vecs[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[3]  = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0};
    vecs[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[6]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7]  = '{16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[8]  = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[9]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[11] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; scale = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 12; i++)
      run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back stream under a 1,0,0 out_ready pattern.
    for (int i = 0; i < 8; i++) begin
      ba[i] = 16'($urandom); bb[i] = 16'($urandom);
      bs[i] = 1'($urandom);  bc[i] = 1'($urandom);
    end
    idx = 0; got = 0; cyc = 0; prev_stall = 0; held_sum = '0;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_sum", sum, held_sum);
      end
      out_ready = (cyc % 3 == 0);
      if (idx < 8) begin
        in_valid = 1'b1;
        a = ba[idx]; b = bb[idx]; sub = bs[idx]; scale = bc[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("bp_unexpected_beat", 1, 0);
        end else begin
          e = expq.pop_front();
          chk($sformatf("bp%0d_sum", got), sum, e[15:0]);
          chk($sformatf("bp%0d_carry", got), carry_out, e[16]);
          chk($sformatf("bp%0d_ovf", got), overflow, e[17]);
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      held_sum = sum;
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, sub, scale));
        idx++;
      end
      cyc++;
    end
    chk("bp_count", got, 8);
    chk("bp_accepted", idx, 8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("bp_no_dup", out_valid, 0);
    end

    // Three beats in flight, then a one-cycle reset with a beat offered.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'h1000 + 16'(i); b = 16'h0101; sub = 1'b0; scale = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    a = 16'h0F0F; b = 16'h0101;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("flush_no_valid%0d", i), out_valid, 0);
      @(negedge clk);
    end
    v_post = '{16'h2468, 16'h1357, 1'b1, 1'b0, 16'h1111, 1'b1, 1'b0};
    run_vec("post_reset", v_post);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor for the FFT32 butterfly datapath.
- Splits the N-bit carry chain into SEGS registered segments, so carry propagation never spans more than N/SEGS bits per cycle.
- Adds per-operation subtract and divide-by-2 scaling modes, plus carry and signed-overflow flags.
- Uses a valid/ready handshake with one-per-cycle throughput.
- Sits between the twiddle multiplier outputs and the stage memory write-back.

## Interface
Parameters:
- N, 16: operand/result width in bits; must be a multiple of SEGS and at least 2.
- SEGS, 4: number of pipeline segments, 1..N; latency equals SEGS; segment width W = N/SEGS.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  N  operand A, two's complement.
- b  in  N  operand B, two's complement.
- sub  in  1  0: A+B; 1: A−B.
- scale  in  1  1: result is the exact (N+1)-bit result arithmetically shifted right by 1 (truncating).
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  N  result.
- carry_out  out  1  raw carry out of bit N−1 (for sub: 1 = no borrow).
- overflow  out  1  signed overflow of the unscaled result; forced to 0 when scale=1.

## Operation
- Effective B: b' = sub ? ~b : b; carry-in c0 = sub.
- Segment s (0..SEGS−1) adds bits [s·W+W−1 : s·W] of A and b' with the carry registered from segment s−1, in pipeline stage s.
- Skew registers delay the upper operand slices, and deskew registers align the lower result slices, so every beat leaves with all N bits coherent.
- Each stage carries a valid bit, sub, and scale along with its data.
- Full result: R = {a[N−1] ^ b'[N−1] ^ carry_out, raw N-bit sum} (N+1 bits, signed).
- Output selection:
  - scale=0: sum = R[N−1:0]; overflow = (a[N−1] == b'[N−1]) && (R[N−1] != a[N−1]).
  - scale=1: sum = R[N:1]; overflow = 0.
- carry_out always reports the raw carry out of bit N−1, independent of scale.
- Ordering is strictly FIFO. There is no beat loss and no duplication.

## Timing
- Reset values: in_ready=1 in the cycle after reset deasserts; out_valid=0, sum=0, carry_out=0, overflow=0; all stage valid bits and data cleared.
- Global advance enable: en = out_ready || !out_valid. in_ready = en, combinational.
- A beat is accepted at edge t when in_valid && in_ready. It appears with out_valid=1 after edge t+SEGS−1, i.e. SEGS cycles of latency, with no stalls in between.
- When en=0, every stage holds. out_valid, sum and flags stay stable until out_ready is sampled high.
- Bubbles (in_valid=0 while en=1) propagate as invalid stages. Bubbles are not compressed.
- Reset has priority over everything. Reset mid-operation discards all in-flight beats; out_valid falls to 0 at the next edge.
- SEGS=1 degenerates to a single registered N-bit adder with latency 1.
- in_valid=1 in the same cycle as reset: the beat is dropped.

## Structure
- Shared package fft_pkg holds:
  - the default data width constant (16);
  - mode encodings OP_ADD=0 and OP_SUB=1;
  - the SEGS range check, enforced at elaboration.
- Sub-module addsub_segment:
  - parameter W; one W-bit ripple slice built from the existing full-adder cell;
  - inputs: slice A, slice B', carry in;
  - outputs: W-bit sum, carry out (combinational only).
- The top level instantiates SEGS segments via generate and owns all skew, deskew, valid and flag registers.

## Test plan
N=16, SEGS=4, out_ready=1 unless stated.
- Reset: hold reset 3 cycles → out_valid=0, sum=0x0000, carry_out=0, overflow=0; in_ready=1 the cycle after release.
- Add overflow: a=0x7FFF, b=0x0001, sub=0, scale=0 → exactly 4 cycles later sum=0x8000, carry_out=0, overflow=1.
- Full-chain carry and subtract:
  - 0xFFFF+0x0001 → sum=0x0000, carry_out=1, overflow=0.
  - Then 0x0000−0x0001 → sum=0xFFFF, carry_out=0, overflow=0.
- Scale: 0x7FFF+0x7FFF with scale=1 → sum=0x7FFF, overflow=0; 0x8000+0x8000 with scale=1 → sum=0x8000, carry_out=1.
- Backpressure: stream 8 random beats back-to-back while out_ready toggles 1,0,0,1,… → outputs match a reference model in order, with no loss or duplication; sum is stable while out_valid=1 and out_ready=0.
- Mid-flight reset: issue 3 beats, assert reset for 1 cycle before any output → no out_valid ever appears for those beats; a new beat issued after reset emerges correctly 4 cycles later.
